// File: rtl/maxpool2x2_stream_pkg.sv
// Shared accelerator types and helpers: pixel widths, signed max and 8-bit saturation.
package maxpool2x2_stream_pkg;

    localparam int PIXEL_W = 32;
    localparam int ACT_W   = 8;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pixel_t sat8(input pixel_t x);
        pixel_t hi;
        pixel_t lo;
        hi = pixel_t'((1 << (ACT_W - 1)) - 1);
        lo = -pixel_t'(1 << (ACT_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Single-lane pixel stream (data + valid strobe, no ready): master drives, slave observes.
interface maxpool2x2_stream_if;
    import maxpool2x2_stream_pkg::*;

    pixel_t pixel;
    logic   valid;

    modport master (output pixel, output valid);
    modport slave  (input  pixel, input  valid);
endinterface

// File: rtl/maxpool_linebuf.sv
// Simple dual-port RAM of even-row pair maxima; one write and one registered read per cycle.
module maxpool_linebuf
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2/stride-2 streaming max-pool, 1-cycle latency from bottom-right pixel; no backpressure.
// MAXPOOL_REQUANT_EN: output becomes sat8(max >>> QSHIFT) sign-extended, else raw 32-bit max.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int MAX_WIDTH = 128,
    parameter int QSHIFT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [7:0]          width,
    input  logic [7:0]          height,
    maxpool2x2_stream_if.slave  src,
    maxpool2x2_stream_if.master snk,
    output logic                frame_done
);

    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    if (QSHIFT < 0 || QSHIFT >= PIXEL_W) begin : g_qshift_range
        $error("QSHIFT out of range");
    end

    logic [7:0] col, row, w, h;
    pixel_t     hold;
    pixel_t     lb_rdata;

    // Geometry is taken live on the first pixel of a frame, latched copy afterwards.
    logic       first;
    logic [7:0] cur_w, cur_h;
    logic       col_last, row_last;
    logic       take, odd_col, odd_row;
    logic [7:0] emit_col_last, emit_row_last;
    pixel_t     pmax, pooled, result;

    assign first    = (row == 8'd0) && (col == 8'd0);
    assign cur_w    = first ? width  : w;
    assign cur_h    = first ? height : h;
    assign col_last = (col == cur_w - 8'd1);
    assign row_last = (row == cur_h - 8'd1);
    assign take     = src.valid && !clear;
    assign odd_col  = col[0];
    assign odd_row  = row[0];

    // An odd trailing row/column is never part of a window, so the last emit sits at the even-rounded edge.
    assign emit_col_last = {w[7:1], 1'b0} - 8'd1;
    assign emit_row_last = {h[7:1], 1'b0} - 8'd1;

    assign pmax   = smax(hold, src.pixel);
    assign pooled = smax(lb_rdata, pmax);

`ifdef MAXPOOL_REQUANT_EN
    assign result = sat8(pooled >>> QSHIFT);
`else
    assign result = pooled;
`endif

    // Read is issued on the even column so the data is waiting when the odd column arrives.
    maxpool_linebuf #(.DEPTH(LB_DEPTH), .AW(LB_AW)) u_linebuf (
        .clk     (clk),
        .wr_en   (take && odd_col && !odd_row),
        .wr_addr (col[LB_AW:1]),
        .wr_data (pmax),
        .rd_en   (take && !odd_col && odd_row),
        .rd_addr (col[LB_AW:1]),
        .rd_data (lb_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            w          <= '0;
            h          <= '0;
            hold       <= '0;
            snk.pixel  <= '0;
            snk.valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            snk.valid  <= 1'b0;
            frame_done <= 1'b0;
            if (clear) begin
                col  <= '0;
                row  <= '0;
                hold <= '0;
            end else if (src.valid) begin
                if (first) begin
                    w <= width;
                    h <= height;
                end
                if (!odd_col) begin
                    hold <= src.pixel;
                end else if (odd_row) begin
                    snk.pixel  <= result;
                    snk.valid  <= 1'b1;
                    frame_done <= (row == emit_row_last) && (col == emit_col_last);
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? 8'd0 : row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule
